// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction-fetch stage with the IF/ID pipeline register.
// Drives the fetch PC, runs a req/ack handshake with instruction memory, and
// hands Inst/Addr to decode. A one-entry hold buffer absorbs a word that
// arrives while decode is stalled. A branch/jump redirect discards in-flight
// fetches.
// Optional feature macro: BRANCH_DELAY_SLOT_EN. When defined, the word at the
// sequential PC after a redirect (the MIPS delay slot) is delivered instead of
// squashed. When undefined, that word is always squashed.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Target,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ack,
  input  logic [31:0] Imem_Rdata,
  output logic [31:0] Inst,
  output logic [31:0] Addr,
  output logic [31:0] D_PC4,
  output logic        D_Valid
);

  // FETCH: normal sequential fetching.
  // DROP:  a redirect left a request outstanding; its data is junk.
  // SLOT:  a redirect left the delay-slot word outstanding; it is delivered.
  typedef enum logic [1:0] {FETCH, DROP, SLOT} state_t;

  state_t      state_q, state_d;
  logic [31:0] f_pc_q, f_pc_d;
  logic        run_q, run_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;

  logic        accept;
  logic [31:0] pc_next;

  assign Imem_Req  = run_q & ~hold_valid_q;
  assign Imem_Addr = f_pc_q;
  assign accept    = Imem_Req & Imem_Ack;
  assign pc_next   = f_pc_q + 32'd4;

  assign Inst    = inst_q;
  assign Addr    = addr_q;
  assign D_PC4   = addr_q + 32'd4;
  assign D_Valid = valid_q;

  // Next-state logic: fetch PC, hold buffer, redirect tracking and IF/ID contents.
  always_comb begin
    state_d      = state_q;
    f_pc_d       = f_pc_q;
    run_d        = 1'b1;
    hold_valid_d = hold_valid_q;
    hold_inst_d  = hold_inst_q;
    hold_pc_d    = hold_pc_q;
    pend_pc_d    = pend_pc_q;
    inst_d       = inst_q;
    addr_d       = addr_q;
    valid_d      = valid_q;

    unique case (state_q)
      FETCH: begin
        if (Redirect) begin
          hold_valid_d = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
          if (hold_valid_q) begin
            inst_d  = hold_inst_q;
            addr_d  = hold_pc_q;
            valid_d = 1'b1;
            f_pc_d  = Target;
          end else if (accept) begin
            inst_d  = Imem_Rdata;
            addr_d  = f_pc_q;
            valid_d = 1'b1;
            f_pc_d  = Target;
          end else begin
            inst_d  = 32'd0;
            valid_d = 1'b0;
            if (Imem_Req) begin
              pend_pc_d = Target;
              state_d   = SLOT;
            end else begin
              f_pc_d = Target;
            end
          end
`else
          inst_d  = 32'd0;
          valid_d = 1'b0;
          if (accept || !Imem_Req) begin
            f_pc_d = Target;
          end else begin
            pend_pc_d = Target;
            state_d   = DROP;
          end
`endif
        end else if (accept) begin
          f_pc_d = pc_next;
          if (Stall) begin
            hold_valid_d = 1'b1;
            hold_inst_d  = Imem_Rdata;
            hold_pc_d    = f_pc_q;
          end else begin
            inst_d  = Imem_Rdata;
            addr_d  = f_pc_q;
            valid_d = 1'b1;
          end
        end else if (!Stall) begin
          if (hold_valid_q) begin
            inst_d       = hold_inst_q;
            addr_d       = hold_pc_q;
            valid_d      = 1'b1;
            hold_valid_d = 1'b0;
          end else begin
            inst_d  = 32'd0;
            valid_d = 1'b0;
          end
        end
      end

      DROP: begin
        if (!Stall || Redirect) begin
          inst_d  = 32'd0;
          valid_d = 1'b0;
        end
        if (accept) begin
          f_pc_d  = Redirect ? Target : pend_pc_q;
          state_d = FETCH;
        end else if (Redirect) begin
          pend_pc_d = Target;
        end
      end

      SLOT: begin
        if (accept) begin
          f_pc_d  = Redirect ? Target : pend_pc_q;
          state_d = FETCH;
          if (Stall && !Redirect) begin
            hold_valid_d = 1'b1;
            hold_inst_d  = Imem_Rdata;
            hold_pc_d    = f_pc_q;
          end else begin
            inst_d  = Imem_Rdata;
            addr_d  = f_pc_q;
            valid_d = 1'b1;
          end
        end else begin
          if (Redirect) begin
            pend_pc_d = Target;
          end
          if (!Stall || Redirect) begin
            inst_d  = 32'd0;
            valid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State registers; Clr abandons any outstanding request and restores reset values.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q      <= FETCH;
      f_pc_q       <= RESET_PC;
      run_q        <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_inst_q  <= 32'd0;
      hold_pc_q    <= 32'd0;
      pend_pc_q    <= 32'd0;
      inst_q       <= 32'd0;
      addr_q       <= 32'd0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      f_pc_q       <= f_pc_d;
      run_q        <= run_d;
      hold_valid_q <= hold_valid_d;
      hold_inst_q  <= hold_inst_d;
      hold_pc_q    <= hold_pc_d;
      pend_pc_q    <= pend_pc_d;
      inst_q       <= inst_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
    end
  end

endmodule
